// File: rtl/mem_sequencer.sv
// mem_sequencer: multi-cycle FETCH/EXEC/MEM/WB sequencer that shares one
// variable-latency memory port between instruction fetch and load/store.
module mem_sequencer #(
    parameter int Dbits   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [Dbits-1:0] pc,
    input  logic [Dbits-1:0] dp_mem_addr,
    input  logic [Dbits-1:0] dp_mem_writedata,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             werf_in,
    output logic [31:0]      instr,
    output logic [Dbits-1:0] dp_mem_readdata,
    output logic             enable,
    output logic             werf,
    output logic             bus_req,
    output logic             bus_we,
    output logic [Dbits-1:0] bus_addr,
    output logic [Dbits-1:0] bus_wdata,
    input  logic             bus_ack,
    input  logic [Dbits-1:0] bus_rdata,
    output logic             bus_err,
    output logic             busy,
    output logic [31:0]      retired
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [16:0] TO = 17'(TIMEOUT);

    state_t      state;
    state_t      state_nx;
    logic [15:0] wait_cnt;

    logic        is_mem;
    logic        pc_ok;
    logic        da_ok;
    logic        ack_ok;
    logic        timed_out;

    assign is_mem = is_load | is_store;
    assign pc_ok  = (pc[1:0] == 2'b00);
    assign da_ok  = (dp_mem_addr[1:0] == 2'b00);

    // An ack only counts while a request is actually outstanding.
    assign ack_ok = bus_req & bus_ack;

    // This cycle is the TIMEOUT-th request cycle without an ack.
    assign timed_out = bus_req & ~bus_ack &
                       (({1'b0, wait_cnt} + 17'd1) >= TO);

    assign busy    = (state != IDLE) && (state != ERROR);
    assign bus_err = (state == ERROR);

    // State register; reset aborts any access immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: alignment is checked before any request goes out.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                if (!pc_ok) begin
                    state_nx = ERROR;
                end else if (ack_ok) begin
                    state_nx = EXEC;
                end else if (timed_out) begin
                    state_nx = ERROR;
                end
            end
            EXEC: begin
                if (is_mem) begin
                    state_nx = da_ok ? MEM : ERROR;
                end else begin
                    state_nx = run ? FETCH : IDLE;
                end
            end
            MEM: begin
                if (ack_ok) begin
                    state_nx = WB;
                end else if (timed_out) begin
                    state_nx = ERROR;
                end
            end
            WB: begin
                state_nx = run ? FETCH : IDLE;
            end
            ERROR: begin
                state_nx = ERROR;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Bus and retire strobes, decoded from state and decoder flags.
    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        enable    = 1'b0;
        werf      = 1'b0;
        unique case (state)
            FETCH: begin
                if (pc_ok) begin
                    bus_req  = 1'b1;
                    bus_addr = pc;
                end
            end
            EXEC: begin
                if (!is_mem) begin
                    enable = 1'b1;
                    werf   = werf_in;
                end
            end
            MEM: begin
                bus_req   = 1'b1;
                bus_addr  = dp_mem_addr;
                bus_we    = is_store;
                bus_wdata = dp_mem_writedata;
            end
            WB: begin
                enable = 1'b1;
                werf   = werf_in & ~is_store;
            end
            default: begin
                bus_req = 1'b0;
            end
        endcase
    end

    // Wait counter: runs only while a request waits, so it is zero on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (bus_req && !bus_ack) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Instruction latch, loaded when the fetch completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= '0;
        end else if (state == FETCH && ack_ok) begin
            instr <= 32'(bus_rdata);
        end
    end

    // Load data latch, loaded when a load access completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_mem_readdata <= '0;
        end else if (state == MEM && ack_ok && is_load) begin
            dp_mem_readdata <= bus_rdata;
        end
    end

    // Retire counter, stepped by the single enable pulse per instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (enable) begin
            retired <= retired + 32'd1;
        end
    end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle sequencer placed between the MIPS datapath and a single shared, variable-latency memory port. It fetches each instruction over the port, holds it for the decoder and datapath, and performs the load/store access on the same port. It produces the datapath `enable` pulse and the gated `werf`, so each instruction retires exactly once, only after all of its bus traffic has completed.

## Interface
Parameters:
- `Dbits`, 32: data and address width.
- `TIMEOUT`, 255: maximum wait cycles for `bus_ack` before error; range 1..65535.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `run`  in  1  level; sequencing is allowed while high.
- `pc`  in  Dbits  current PC from the datapath.
- `dp_mem_addr`  in  Dbits  datapath ALU result (load/store address).
- `dp_mem_writedata`  in  Dbits  store data from the datapath.
- `is_load`, `is_store`  in  1 each  decoder flags for the held `instr`; never both high.
- `werf_in`  in  1  decoder register-write request.
- `instr`  out  32  latched instruction fed to the decoder and datapath.
- `dp_mem_readdata`  out  Dbits  latched load data fed to the datapath.
- `enable`  out  1  one-cycle PC-advance pulse to the datapath.
- `werf`  out  1  gated register-file write enable.
- `bus_req`, `bus_we`  out  1 each  memory request and write strobe.
- `bus_addr`, `bus_wdata`  out  Dbits  request address and write data.
- `bus_ack`  in  1  memory completion.
- `bus_rdata`  in  Dbits  memory read data, valid with `bus_ack`.
- `bus_err`  out  1  sticky error flag.
- `busy`  out  1  high in any state except IDLE and ERROR.
- `retired`  out  32  count of retired instructions.

## Operation
States are IDLE, FETCH, EXEC, MEM, WB and ERROR.

- **IDLE**: go to FETCH when `run`=1.
- **FETCH**:
  - Drive `bus_req`=1, `bus_we`=0, `bus_addr`=`pc`.
  - On `bus_ack`: latch `instr`<=`bus_rdata` and go to EXEC.
- **EXEC** (one cycle; decoder and ALU settle on the held `instr`):
  - If `is_load` or `is_store`: go to MEM.
  - Otherwise: `enable`=1, `werf`=`werf_in`, `retired`+1, then go to FETCH if `run`=1, else IDLE.
- **MEM**:
  - Drive `bus_req`=1, `bus_addr`=`dp_mem_addr`, `bus_we`=`is_store`, `bus_wdata`=`dp_mem_writedata`.
  - On `bus_ack`: if a load, latch `dp_mem_readdata`<=`bus_rdata`. Go to WB.
- **WB**:
  - `enable`=1, `werf`=`werf_in` & ~`is_store`, `retired`+1.
  - Go to FETCH if `run`=1, else IDLE.
- **ERROR**: terminal until reset. `bus_err`=1, `bus_req`=0, `enable`=0, `werf`=0.

Outputs and counters:
- `enable` and `werf` are asserted only in EXEC (non-memory instruction) and WB; 0 elsewhere.
- `bus_we` and `bus_wdata` are 0 whenever `bus_req`=0.
- Wait counter: 16-bit. Cleared on entry to FETCH or MEM and incremented each cycle `bus_req`=1 without `bus_ack`. Reaching `TIMEOUT` goes to ERROR.
- Alignment: if `bus_addr[1:0]`≠0 on entry to FETCH or MEM, go directly to ERROR. `bus_req` is never asserted for that access.
- `retired` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (asynchronous, immediate): state=IDLE. `instr`, `dp_mem_readdata`, `retired` and the wait counter are 0. `enable`, `werf`, `bus_req`, `bus_we`, `bus_err` and `busy` are 0. `bus_addr` and `bus_wdata` are 0.
- Reset mid-transaction aborts immediately; `bus_req` drops in the same cycle. No retire, no register write.
- Handshake:
  - `bus_req` and its address, we and data are held stable until the edge where `bus_ack`=1 is sampled.
  - Zero-wait ack (ack in the same cycle as the first req cycle) is legal.
  - `bus_ack` while `bus_req`=0 is ignored.
  - `bus_req` falls in the cycle after ack, except back-to-back FETCH→… never occurs: EXEC or WB always separates accesses.
- Latency with zero-wait memory:
  - ALU/branch/jump instruction: 2 cycles (FETCH, EXEC).
  - Load or store: 4 cycles (FETCH, EXEC, MEM, WB).
  - Each memory wait cycle adds 1.
- `run` is sampled only in IDLE, EXEC (non-memory) and WB. Dropping `run` mid-instruction completes that instruction, then stops in IDLE.
- `enable` and `werf` are combinational from state and decoder inputs, and are high for exactly one cycle per instruction.

## Test plan
- **ALU stream**: `run`=1, zero-wait memory, 3 non-memory instructions, `pc`=0x00400000/04/08.
  - FETCH addresses must be 0x00400000/04/08.
  - `enable` pulses must occur every 2nd cycle.
  - `retired`=3 at the end.
- **Load with 3 wait cycles**: `dp_mem_addr`=0x10010000, `bus_rdata`=0xDEADBEEF.
  - `bus_req` held for 4 cycles with stable address.
  - `dp_mem_readdata`=0xDEADBEEF in WB, with `werf`=1 and `enable`=1 for one cycle.
  - Instruction total is 7 cycles.
- **Store**: `dp_mem_writedata`=0x12345678.
  - `bus_we`=1 with `bus_wdata`=0x12345678 in MEM.
  - In WB, `werf`=0 and `enable`=1.
- **Timeout**: `TIMEOUT`=4 and `bus_ack` held at 0.
  - ERROR entered after 4 request cycles.
  - `bus_err`=1 and `bus_req`=0 until reset; no further `enable`.
- **Misaligned store**: `dp_mem_addr`=0x10010002.
  - ERROR entered directly from EXEC.
  - `bus_req` never asserted for the store; `retired` unchanged.
- **Reset and run drop**:
  - Assert `reset` mid-MEM: all outputs 0 in the same cycle, state IDLE.
  - Drop `run` during FETCH: that instruction retires, then the block stays in IDLE with `busy`=0.
